reg_file16: RTL and testbench
=============================

REG_FILE16 -- requirements
Module: reg_file16

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and data port.
REQ-002 Parameter N_REGS, default 16: register count; fixed at 16, matching the 16-bit one-hot write-select.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 wr_sel_1h  input  16  one-hot write select from the upstream 4-to-16 write decoder; bit i selects register i.
REQ-006 wr_data  input  DATA_W  write data, sampled with wr_sel_1h.
REQ-007 rd_en  input  1  read request for both read ports.
REQ-008 rd_addr_a  input  4  read port A register index.
REQ-009 rd_addr_b  input  4  read port B register index.
REQ-010 rd_data_a  output  DATA_W  registered read data, port A.
REQ-011 rd_data_b  output  DATA_W  registered read data, port B.
REQ-012 rd_valid  output  1  high for one cycle when rd_data_a/b carry the result of a read.
REQ-013 wr_err  output  1  one-cycle pulse flagging an illegal write select.
REQ-014 err_cnt  output  8  saturating count of illegal write selects.

Function
REQ-015 Write, exactly one bit i set in wr_sel_1h: register i SHALL take wr_data at the rising edge.
REQ-016 Write, wr_sel_1h == 0: no register SHALL change; not an error.
REQ-017 Write, two or more bits set: no register SHALL change.
- REQ-017a wr_err SHALL be 1 in the following cycle only.
- REQ-017b err_cnt SHALL increment by 1 in the following cycle, saturating at 255.
REQ-018 Read latency: with rd_en = 1 at edge N, rd_data_a/b SHALL present the addressed registers and rd_valid SHALL be 1 after edge N.
REQ-019 With rd_en = 0 at an edge, rd_valid SHALL be 0 and rd_data_a/b SHALL hold their previous values.
REQ-020 Write-first bypass: when a legal write targets the register being read at the same edge, that port SHALL return the new wr_data; each port applies this independently.
REQ-021 An illegal write select SHALL never be bypassed; reads return the stored value.
REQ-022 rd_addr_a == rd_addr_b is legal; both ports SHALL return identical data.
REQ-023 Back-to-back reads, one per cycle, SHALL be supported with rd_valid continuously high.
REQ-024 Register contents are storage only; the block performs no arithmetic on data.

Reset
REQ-025 On rst_n low, asynchronously and without a clock:
- all 16 registers SHALL be 0;
- rd_data_a/b SHALL be 0;
- rd_valid, wr_err and err_cnt SHALL be 0.
REQ-026 A write or read in flight when rst_n falls SHALL be discarded; no write lands and rd_valid stays 0.
REQ-027 The first edge after rst_n rises SHALL be processed normally.

Structure
REQ-028 Shared package regfile_pkg SHALL hold DATA_W, N_REGS, ADDR_W = 4 and ERR_CNT_W = 8.
REQ-029 Sub-module onehot_chk SHALL take wr_sel_1h and produce two flags:
- is_zero;
- is_multi (two or more bits set).
It SHALL be purely combinational and instantiated once.

Verification
REQ-030 Reset, then read all 16 registers -> every rd_data_a/b = 0x00000000, with rd_valid = 1 one cycle after each request.
REQ-031 Write 0xDEADBEEF with wr_sel_1h = 0x0020, then read with rd_addr_a = 5 and rd_addr_b = 4 -> next cycle rd_data_a = 0xDEADBEEF, rd_data_b = 0.
REQ-032 Same edge: wr_sel_1h = 0x8000 with wr_data = 0x12345678, rd_en = 1, rd_addr_a = rd_addr_b = 15 -> both ports = 0x12345678 next cycle.
REQ-033 wr_sel_1h = 0x0003 with wr_data = 0xFFFFFFFF -> registers 0 and 1 unchanged, wr_err pulses for one cycle, err_cnt = 1; 300 further illegal selects -> err_cnt = 255.
REQ-034 Assert rst_n low mid-stream, after writing 0xA5A5A5A5 to register 3 and while a read of register 3 is pending -> rd_valid stays 0, and a read after reset returns 0.
REQ-035 wr_sel_1h = 0 for 10 cycles with random wr_data -> no register changes and wr_err stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared sizes for the 16-entry register file
// Purpose: common widths and counts used by reg_file16, its interface and onehot_chk.
// Ports: none (package).
package regfile_pkg;
    localparam int DATA_W    = 32;
    localparam int N_REGS    = 16;
    localparam int ADDR_W    = 4;
    localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/reg_file16_if.sv
// rtl/reg_file16_if.sv - write/read bus bundle for reg_file16
// Purpose: groups the one-hot write port, the dual read port and the error status.
// Ports: master drives wr_sel_1h/wr_data/rd_en/rd_addr_a/rd_addr_b and observes
//        rd_data_a/rd_data_b/rd_valid/wr_err/err_cnt; slave is the mirror image.
interface reg_file16_if
    import regfile_pkg::*;
#(
    parameter int DW = regfile_pkg::DATA_W
);
    logic [N_REGS-1:0]    wr_sel_1h;
    logic [DW-1:0]        wr_data;
    logic                 rd_en;
    logic [ADDR_W-1:0]    rd_addr_a;
    logic [ADDR_W-1:0]    rd_addr_b;
    logic [DW-1:0]        rd_data_a;
    logic [DW-1:0]        rd_data_b;
    logic                 rd_valid;
    logic                 wr_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output wr_sel_1h, wr_data, rd_en, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, rd_valid, wr_err, err_cnt
    );

    modport slave (
        input  wr_sel_1h, wr_data, rd_en, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, rd_valid, wr_err, err_cnt
    );
endinterface

// File: rtl/onehot_chk.sv
// rtl/onehot_chk.sv - classifies a write select as empty or multi-hot
// Purpose: purely combinational legality check of the one-hot write select.
// Ports: wr_sel_1h (in, N_REGS); is_zero (out, no bit set); is_multi (out, two or more bits set).
module onehot_chk
    import regfile_pkg::*;
(
    input  logic [N_REGS-1:0] wr_sel_1h,
    output logic              is_zero,
    output logic              is_multi
);
    // Clearing the lowest set bit leaves something only if a second bit was set.
    assign is_zero  = (wr_sel_1h == '0);
    assign is_multi = |(wr_sel_1h & (wr_sel_1h - N_REGS'(1)));
endmodule

// File: rtl/reg_file16.sv
// rtl/reg_file16.sv - 16-entry register file, one-hot write, dual registered read
// Purpose: stores DATA_W-bit words, writes through a one-hot select, reads two ports
//          with one cycle latency and write-first bypass; flags and counts multi-hot selects.
// Ports: clk, rst_n (async active-low); bus (reg_file16_if.slave) carrying
//        wr_sel_1h, wr_data, rd_en, rd_addr_a/b in and rd_data_a/b, rd_valid, wr_err, err_cnt out.
module reg_file16
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int N_REGS = regfile_pkg::N_REGS
)(
    input  logic         clk,
    input  logic         rst_n,
    reg_file16_if.slave  bus
);
    logic [DATA_W-1:0]    regs [N_REGS];
    logic                 is_zero;
    logic                 is_multi;
    logic                 wr_legal;
    logic [DATA_W-1:0]    byp_a;
    logic [DATA_W-1:0]    byp_b;
    logic [DATA_W-1:0]    rd_data_a_q;
    logic [DATA_W-1:0]    rd_data_b_q;
    logic                 rd_valid_q;
    logic                 wr_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    onehot_chk u_onehot_chk (
        .wr_sel_1h (bus.wr_sel_1h),
        .is_zero   (is_zero),
        .is_multi  (is_multi)
    );

    assign wr_legal = !is_zero && !is_multi;

    // Write-first: a legal write to the addressed register is forwarded to that port.
    // A multi-hot select never forwards, so the stored value is returned.
    always_comb begin
        byp_a = regs[bus.rd_addr_a];
        byp_b = regs[bus.rd_addr_b];
        if (wr_legal && bus.wr_sel_1h[bus.rd_addr_a]) begin
            byp_a = bus.wr_data;
        end
        if (wr_legal && bus.wr_sel_1h[bus.rd_addr_b]) begin
            byp_b = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_legal) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (bus.wr_sel_1h[i]) begin
                    regs[i] <= bus.wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_a_q <= byp_a;
                rd_data_b_q <= byp_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_err_q  <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_err_q <= is_multi;
            if (is_multi && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.rd_data_a = rd_data_a_q;
    assign bus.rd_data_b = rd_data_b_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.wr_err    = wr_err_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_reg_file16.sv
// tb/tb_reg_file16.sv - self-checking bench for reg_file16
module tb_reg_file16;
    logic clk;
    logic rst_n;

    reg_file16_if bus ();

    reg_file16 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks;
    int failures;

    // Reference model: plain array plus expected output values.
    logic [31:0] model [16];
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic        exp_valid;
    logic        exp_err;
    int          m_cnt;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        exp_a = 32'h0;
        exp_b = 32'h0;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_step(input logic [15:0] sel, input logic [31:0] d,
                              input logic re, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = $countones(sel);
        if (re) begin
            exp_a = (n == 1 && sel[a]) ? d : model[a];
            exp_b = (n == 1 && sel[b]) ? d : model[b];
        end
        exp_valid = re;
        exp_err = (n >= 2);
        if (n >= 2 && m_cnt < 255) m_cnt = m_cnt + 1;
        if (n == 1) begin
            for (int i = 0; i < 16; i++) if (sel[i]) model[i] = d;
        end
    endtask

    // Apply one cycle of stimulus, update the model, sample 1 time unit after the edge.
    task automatic step(input logic [15:0] sel, input logic [31:0] d,
                        input logic re, input logic [3:0] a, input logic [3:0] b);
        @(negedge clk);
        bus.wr_sel_1h = sel;
        bus.wr_data   = d;
        bus.rd_en     = re;
        bus.rd_addr_a = a;
        bus.rd_addr_b = b;
        model_step(sel, d, re, a, b);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_sel_1h = 16'h0;
        bus.wr_data   = 32'h0;
        bus.rd_en     = 1'b0;
        bus.rd_addr_a = 4'h0;
        bus.rd_addr_b = 4'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle_inputs();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.wr_err !== 1'b0 || bus.err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL reset_flags: got valid=%b err=%b cnt=%0d want 0/0/0",
                     bus.rd_valid, bus.wr_err, bus.err_cnt);
        end
        checks++;
        if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got a=%h b=%h want 0/0", bus.rd_data_a, bus.rd_data_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read_all_zero();
        for (int i = 0; i < 16; i++) begin
            step(16'h0, 32'h0, 1'b1, 4'(i), 4'(15 - i));
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
                failures++;
                $display("FAIL read_zero[%0d]: got valid=%b a=%h b=%h want 1/0/0",
                         i, bus.rd_valid, bus.rd_data_a, bus.rd_data_b);
            end
        end
    endtask

    task automatic test_write_read();
        step(16'h0020, 32'hDEADBEEF, 1'b0, 4'h0, 4'h0);
        checks++;
        if (bus.rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL write_no_valid: got %b want 0", bus.rd_valid);
        end
        step(16'h0, 32'h0, 1'b1, 4'd5, 4'd4);
        checks++;
        if (bus.rd_data_a !== 32'hDEADBEEF || bus.rd_data_b !== 32'h0 || bus.rd_valid !== 1'b1) begin
            failures++;
            $display("FAIL write_read: got a=%h b=%h v=%b want deadbeef/0/1",
                     bus.rd_data_a, bus.rd_data_b, bus.rd_valid);
        end
        step(16'h0, 32'h0, 1'b0, 4'd0, 4'd0);
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data_a !== 32'hDEADBEEF || bus.rd_data_b !== 32'h0) begin
            failures++;
            $display("FAIL read_hold: got a=%h b=%h v=%b want deadbeef/0/0",
                     bus.rd_data_a, bus.rd_data_b, bus.rd_valid);
        end
    endtask

    task automatic test_bypass();
        step(16'h8000, 32'h12345678, 1'b1, 4'd15, 4'd15);
        checks++;
        if (bus.rd_data_a !== 32'h12345678 || bus.rd_data_b !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_same: got a=%h b=%h want 12345678", bus.rd_data_a, bus.rd_data_b);
        end
        // Bypass only on the port that targets the written register.
        step(16'h0004, 32'hCAFEF00D, 1'b1, 4'd2, 4'd15);
        checks++;
        if (bus.rd_data_a !== 32'hCAFEF00D || bus.rd_data_b !== 32'h12345678) begin
            failures++;
            $display("FAIL bypass_split: got a=%h b=%h want cafef00d/12345678",
                     bus.rd_data_a, bus.rd_data_b);
        end
    endtask

    task automatic test_illegal();
        logic [15:0] sel;
        apply_reset();
        step(16'h0003, 32'hFFFFFFFF, 1'b1, 4'd0, 4'd1);
        checks++;
        if (bus.wr_err !== 1'b1 || bus.err_cnt !== 8'd1) begin
            failures++;
            $display("FAIL illegal_flag: got err=%b cnt=%0d want 1/1", bus.wr_err, bus.err_cnt);
        end
        checks++;
        if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
            failures++;
            $display("FAIL illegal_no_bypass: got a=%h b=%h want 0/0", bus.rd_data_a, bus.rd_data_b);
        end
        step(16'h0, 32'h0, 1'b1, 4'd0, 4'd1);
        checks++;
        if (bus.wr_err !== 1'b0 || bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
            failures++;
            $display("FAIL illegal_after: got err=%b a=%h b=%h want 0/0/0",
                     bus.wr_err, bus.rd_data_a, bus.rd_data_b);
        end
        for (int i = 0; i < 300; i++) begin
            do sel = 16'($urandom); while ($countones(sel) < 2);
            step(sel, $urandom, 1'b0, 4'd0, 4'd0);
        end
        checks++;
        if (bus.err_cnt !== 8'd255 || m_cnt != 255) begin
            failures++;
            $display("FAIL err_saturate: got %0d want 255", bus.err_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            step(16'h0, 32'h0, 1'b1, 4'(i), 4'(i));
            checks++;
            if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
                failures++;
                $display("FAIL illegal_no_write[%0d]: got a=%h b=%h want 0", i, bus.rd_data_a, bus.rd_data_b);
            end
        end
    endtask

    task automatic test_reset_midstream();
        step(16'h0008, 32'hA5A5A5A5, 1'b0, 4'd0, 4'd0);
        @(negedge clk);
        bus.wr_sel_1h = 16'h0008;
        bus.wr_data   = 32'h5A5A5A5A;
        bus.rd_en     = 1'b1;
        bus.rd_addr_a = 4'd3;
        bus.rd_addr_b = 4'd3;
        #2;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        checks++;
        if (bus.rd_valid !== 1'b0 || bus.rd_data_a !== 32'h0) begin
            failures++;
            $display("FAIL midreset_valid: got v=%b a=%h want 0/0", bus.rd_valid, bus.rd_data_a);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        step(16'h0, 32'h0, 1'b1, 4'd3, 4'd3);
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
            failures++;
            $display("FAIL midreset_read: got v=%b a=%h b=%h want 1/0/0",
                     bus.rd_valid, bus.rd_data_a, bus.rd_data_b);
        end
    endtask

    task automatic test_idle_writes();
        for (int i = 0; i < 16; i++) step(16'(1 << i), $urandom, 1'b0, 4'd0, 4'd0);
        for (int i = 0; i < 10; i++) begin
            step(16'h0, $urandom, 1'b0, 4'd0, 4'd0);
            checks++;
            if (bus.wr_err !== 1'b0) begin
                failures++;
                $display("FAIL idle_err[%0d]: got %b want 0", i, bus.wr_err);
            end
        end
        for (int i = 0; i < 16; i++) begin
            step(16'h0, 32'h0, 1'b1, 4'(i), 4'(i));
            checks++;
            if (bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
                failures++;
                $display("FAIL idle_keep[%0d]: got a=%h b=%h want %h", i, bus.rd_data_a, bus.rd_data_b, exp_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            step(16'h0, 32'h0, 1'b1, 4'($urandom), 4'($urandom));
            checks++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b) begin
                failures++;
                $display("FAIL b2b[%0d]: got v=%b a=%h b=%h want 1/%h/%h",
                         i, bus.rd_valid, bus.rd_data_a, bus.rd_data_b, exp_a, exp_b);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] sel;
        logic [3:0]  a;
        logic [3:0]  b;
        logic [3:0]  w;
        for (int i = 0; i < 400; i++) begin
            w = 4'($urandom);
            case ($urandom_range(0, 3))
                0: sel = 16'h0;
                1, 2: sel = 16'(1 << w);
                default: do sel = 16'($urandom); while ($countones(sel) < 2);
            endcase
            a = ($urandom_range(0, 2) == 0) ? w : 4'($urandom);
            b = ($urandom_range(0, 2) == 0) ? w : 4'($urandom);
            step(sel, $urandom, 1'($urandom), a, b);
            checks++;
            if (bus.rd_valid !== exp_valid || bus.rd_data_a !== exp_a || bus.rd_data_b !== exp_b ||
                bus.wr_err !== exp_err || bus.err_cnt !== 8'(m_cnt)) begin
                failures++;
                $display("FAIL random[%0d]: got v=%b a=%h b=%h e=%b c=%0d want %b/%h/%h/%b/%0d",
                         i, bus.rd_valid, bus.rd_data_a, bus.rd_data_b, bus.wr_err, bus.err_cnt,
                         exp_valid, exp_a, exp_b, exp_err, m_cnt);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_read_all_zero();
        test_write_read();
        test_bypass();
        test_illegal();
        test_reset_midstream();
        test_idle_writes();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
